// File: rtl/instr_fetch_unit_pkg.sv
// Shared definitions for the instruction fetch unit: opcode width and fetch FSM state encodings.
package instr_fetch_unit_pkg;

    localparam int INSTR_OPCODE_WIDTH = 7;

    typedef enum logic [1:0] {
        FETCH_STATE_IDLE = 2'd0,
        FETCH_STATE_REQ  = 2'd1,
        FETCH_STATE_WAIT = 2'd2,
        FETCH_STATE_DONE = 2'd3
    } fetch_state_e;

endpackage

// File: rtl/instr_fetch_unit_pc_reg.sv
// Program counter register; misaligned writes are dropped and latch a sticky fault.
module pc_reg #(
    parameter int              XLEN         = 32,
    parameter logic [XLEN-1:0] RESET_VECTOR = '0
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            PCWrite,
    input  logic [XLEN-1:0] pcNext,
    output logic [XLEN-1:0] pc,
    output logic            misalignFault
);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc            <= RESET_VECTOR;
            misalignFault <= 1'b0;
        end else if (PCWrite) begin
            if (pcNext[1:0] == 2'b00) begin
                pc <= pcNext;
            end else begin
                misalignFault <= 1'b1;
            end
        end
    end

endmodule

// File: rtl/instr_fetch_unit.sv
// Instruction fetch unit: single-outstanding fetch FSM, instruction register and PC.
//   state | meaning
//   IDLE  | waiting for fetchStart; captures pc as the fetch address
//   REQ   | imemReqValid high with stable address until imemReqReady
//   WAIT  | request accepted; waiting for imemRspValid to load IR
//   DONE  | IR holds the new instruction; fetchDone pulses for one cycle
module instr_fetch_unit
    import instr_fetch_unit_pkg::*;
#(
    parameter int              XLEN         = 32,
    parameter logic [XLEN-1:0] RESET_VECTOR = '0
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          fetchStart,
    input  logic                          PCWrite,
    input  logic [XLEN-1:0]               pcNext,
    output logic                          imemReqValid,
    input  logic                          imemReqReady,
    output logic [XLEN-1:0]               imemAddr,
    input  logic                          imemRspValid,
    input  logic [XLEN-1:0]               imemRspData,
    output logic [XLEN-1:0]               pc,
    output logic [XLEN-1:0]               instr,
    output logic [INSTR_OPCODE_WIDTH-1:0] opCode,
    output logic                          fetchDone,
    output logic                          misalignFault
);

    fetch_state_e    state;
    fetch_state_e    state_next;
    logic [XLEN-1:0] fetch_addr;
    logic [XLEN-1:0] ir;

    pc_reg #(
        .XLEN         (XLEN),
        .RESET_VECTOR (RESET_VECTOR)
    ) u_pc_reg (
        .clk           (clk),
        .rst           (rst),
        .PCWrite       (PCWrite),
        .pcNext        (pcNext),
        .pc            (pc),
        .misalignFault (misalignFault)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= FETCH_STATE_IDLE;
            fetch_addr <= RESET_VECTOR;
            ir         <= '0;
        end else begin
            state <= state_next;
            // fetch_addr samples the pc before any same-cycle PCWrite lands
            if (state == FETCH_STATE_IDLE && fetchStart) begin
                fetch_addr <= pc;
            end
            if (state == FETCH_STATE_WAIT && imemRspValid) begin
                ir <= imemRspData;
            end
        end
    end

    always_comb begin
        state_next   = state;
        imemReqValid = 1'b0;
        fetchDone    = 1'b0;
        case (state)
            FETCH_STATE_IDLE: begin
                if (fetchStart) state_next = FETCH_STATE_REQ;
            end
            FETCH_STATE_REQ: begin
                imemReqValid = 1'b1;
                if (imemReqReady) state_next = FETCH_STATE_WAIT;
            end
            FETCH_STATE_WAIT: begin
                if (imemRspValid) state_next = FETCH_STATE_DONE;
            end
            FETCH_STATE_DONE: begin
                fetchDone  = 1'b1;
                state_next = FETCH_STATE_IDLE;
            end
            default: state_next = FETCH_STATE_IDLE;
        endcase
    end

    assign imemAddr = fetch_addr;
    assign instr    = ir;
    assign opCode   = ir[INSTR_OPCODE_WIDTH-1:0];

endmodule

// File: doc/instr_fetch_unit.md
INSTR_FETCH_UNIT -- requirements
Module: instr_fetch_unit

Interface
REQ-001 Parameter RESET_VECTOR, default 32'h0000_0000: PC value loaded by reset.
REQ-002 Parameter XLEN, default 32: PC and instruction width.
REQ-003 clk  in  1  single clock; all state updates on rising edge.
REQ-004 rst  in  1  reset; asynchronous, active-high.
REQ-005 fetchStart  in  1  one-cycle pulse from main_controller in FETCH state; requests fetch at current PC.
REQ-006 PCWrite  in  1  load pcNext into PC this cycle.
REQ-007 pcNext  in  XLEN  next PC value from ALU result.
REQ-008 imemReqValid  out  1  instruction-memory read request valid.
REQ-009 imemReqReady  in  1  memory accepts request.
REQ-010 imemAddr  out  XLEN  request address.
REQ-011 imemRspValid  in  1  read data valid.
REQ-012 imemRspData  in  XLEN  read data.
REQ-013 pc  out  XLEN  current PC.
REQ-014 instr  out  XLEN  instruction register contents.
REQ-015 opCode  out  INSTR_OPCODE_WIDTH  instr[6:0], combinational from IR.
REQ-016 fetchDone  out  1  one-cycle pulse: IR holds new instruction.
REQ-017 misalignFault  out  1  sticky: PCWrite attempted with pcNext[1:0] != 0.

Function
REQ-018 FSM states IDLE, REQ, WAIT, DONE; IDLE is the reset state.
REQ-019 IDLE: fetchStart=1 -> capture pc into internal fetchAddr, go to REQ; otherwise stay.
REQ-020 REQ: imemReqValid=1, imemAddr=fetchAddr; imemReqReady=1 -> WAIT; else hold valid and address stable.
REQ-021 WAIT: imemRspValid=1 -> IR <= imemRspData, go to DONE; else stay, no timeout.
REQ-022 DONE: fetchDone=1 for exactly one cycle, then IDLE.
REQ-023 Best-case latency fetchStart to fetchDone is 3 cycles (ready and response each in the first cycle offered).
REQ-024 fetchStart outside IDLE is ignored; no queueing.
REQ-025 imemRspValid outside WAIT is ignored; IR unchanged.
REQ-026 IR changes only on the WAIT->DONE transition; instr/opCode stable otherwise.
REQ-027 PCWrite=1 with pcNext[1:0]==0: pc <= pcNext next cycle, in any FSM state.
REQ-028 PCWrite=1 with pcNext[1:0]!=0: pc unchanged, misalignFault <= 1, held until reset.
REQ-029 PC update during REQ/WAIT does not alter fetchAddr or the in-flight fetch.
REQ-030 fetchStart and PCWrite in the same IDLE cycle: fetchAddr takes the old pc.
REQ-031 imemReqValid=0 in all states other than REQ.

Reset
REQ-032 rst=1 asynchronously: state=IDLE, pc=RESET_VECTOR, fetchAddr=RESET_VECTOR, IR=0, fetchDone=0, imemReqValid=0, misalignFault=0.
REQ-033 rst asserted mid-fetch abandons the transaction; any later response is ignored per REQ-025.
REQ-034 First fetchStart after reset release is honoured in the first clock with rst=0.

Structure
REQ-035 INSTR_OPCODE_WIDTH comes from instr_defines.h; the FETCH_STATE_* encodings (2-bit) go in a new shared fetch_state_defines.h.
REQ-036 PC register with alignment check is a sub-module pc_reg (clk, rst, PCWrite, pcNext, pc, misalignFault); FSM and IR stay in the top module.

Verification
REQ-037 Reset, fetchStart, ready=1 and rsp same cycles, data 32'h0000_0033 -> imemAddr=0, fetchDone at cycle 3, opCode=7'h33.
REQ-038 Ready held low 4 cycles -> imemReqValid and imemAddr stable 5 cycles, single accept, fetchDone once.
REQ-039 PCWrite pcNext=32'h4 during WAIT -> imemAddr stays 0, pc=4 next cycle, next fetch issues address 4.
REQ-040 PCWrite pcNext=32'h6 -> pc unchanged, misalignFault=1 sticky until rst.
REQ-041 rst pulsed during WAIT, stray imemRspValid data 32'hDEAD_BEEF afterwards -> IR=0, no fetchDone.
REQ-042 fetchStart pulses during REQ and WAIT -> ignored; exactly one transaction and one fetchDone.
